// File: rtl/wallace_pkg.sv
// Shared constants, FSM state type and truncation-mask helper for the
// Wallace-tree MAC sequencer.
package wallace_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  // Keeps product bits at or above column 'cols'; lower columns read as zero.
  function automatic logic [PROD_W-1:0] approx_mask(input logic [2:0] cols);
    return ~((PROD_W'(1) << cols) - PROD_W'(1));
  endfunction

endpackage

// File: rtl/wallace_lat_tracker.sv
// Valid shift register that mirrors the multiplier pipeline depth so the
// sequencer knows which cycle carries a real product on mul_p.
module wallace_lat_tracker #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  output logic prod_valid,
  output logic empty
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  assign pipe_d[0] = push;
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    assign pipe_d[gi] = pipe_q[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else if (flush) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign prod_valid = pipe_q[DEPTH-1];
  assign empty      = ~|pipe_q;

endmodule

// File: rtl/wallace_mac_sequencer.sv
// Drives an external Wallace-tree multiplier through an N-element dot product
// and accumulates the (optionally LSB-truncated) products.
module wallace_mac_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int LEN_W    = 8,
  parameter int MULT_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [2:0]          approx_cols,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_p,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_acc,
  output logic                overflow,
  output logic                busy
);
  import wallace_pkg::*;

  localparam int PW = 2 * DATA_W;

  seq_state_t        state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    issued_q;
  logic [LEN_W:0]    retired_q;
  logic [PW-1:0]     mask_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] mul_a_q;
  logic [DATA_W-1:0] mul_b_q;

  logic [LEN_W:0]    issued_d;
  logic [LEN_W:0]    retired_d;
  logic [LEN_W:0]    len_ext;
  logic [ACC_W:0]    acc_sum;
  logic [PW-1:0]     mask_d;
  logic [PROD_W-1:0] pkg_mask;
  logic              hs;
  logic              start_ok;
  logic              prod_valid;
  logic              pipe_empty;

  // Package mask covers the low columns; any wider product keeps its upper bits.
  assign pkg_mask = approx_mask(approx_cols);
  for (genvar gi = 0; gi < PW; gi++) begin : g_mask
    if (gi < PROD_W) begin : g_lo
      assign mask_d[gi] = pkg_mask[gi];
    end else begin : g_hi
      assign mask_d[gi] = 1'b1;
    end
  end

  assign hs        = in_valid & in_ready_q;
  assign start_ok  = (state_q == IDLE) & start;
  assign issued_d  = issued_q + (LEN_W+1)'(hs);
  assign retired_d = retired_q + (LEN_W+1)'(prod_valid);
  assign len_ext   = {1'b0, len_q};
  assign acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(mul_p & mask_q);

  wallace_lat_tracker #(
    .DEPTH(MULT_LAT + 1)
  ) u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (start_ok),
    .push       (hs),
    .prod_valid (prod_valid),
    .empty      (pipe_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      if (hs) begin
        mul_a_q  <= in_a;
        mul_b_q  <= in_b;
        issued_q <= issued_d;
      end
      if (prod_valid) begin
        acc_q     <= acc_sum[ACC_W-1:0];
        ovf_q     <= ovf_q | acc_sum[ACC_W];
        retired_q <= retired_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q     <= len;
            mask_q    <= mask_d;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            issued_q  <= '0;
            retired_q <= '0;
            busy_q    <= 1'b1;
            if (len != '0) begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issued_d == len_ext) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          // The final retire and the move to DONE share an edge.
          if ((retired_d == len_ext) || (pipe_empty && retired_q == len_ext)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Table-driven bench: two sequencers (24-bit and 16-bit accumulators) share
// one operand stream; each drives its own 2-stage registered a*b model.
module tb_wallace_mac_sequencer;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len_in = '0;
  logic [2:0]  approx_in = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, in_ready16;
  logic [7:0]  mul_a, mul_b, mul_a16, mul_b16;
  logic [15:0] mul_p, mul_p16;
  logic        out_valid, out_valid16;
  logic [23:0] out_acc;
  logic [15:0] out_acc16;
  logic        overflow, overflow16;
  logic        busy, busy16;

  logic [15:0] pa0, pa1, pb0, pb1;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: ML register stages after the registered operands.
  always @(posedge clk) begin
    pa0 <= 16'(mul_a) * 16'(mul_b);
    pa1 <= pa0;
    pb0 <= 16'(mul_a16) * 16'(mul_b16);
    pb1 <= pb0;
  end
  assign mul_p   = pa1;
  assign mul_p16 = pb1;

  wallace_mac_sequencer #(.DATA_W(8), .ACC_W(24), .LEN_W(8), .MULT_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len_in), .approx_cols(approx_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .overflow(overflow), .busy(busy)
  );

  wallace_mac_sequencer #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .MULT_LAT(ML)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len_in), .approx_cols(approx_in),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_p(mul_p16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
    .overflow(overflow16), .busy(busy16)
  );

  typedef struct {
    int             len;
    int             approx;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][2:0] gap;
    int             dly;
    logic [23:0]    e24;
    logic           ov24;
    logic [15:0]    e16;
    logic           ov16;
  } vec_t;

  typedef struct {
    logic [23:0] e24;
    logic        ov24;
    logic [15:0] e16;
    logic        ov16;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];

  function automatic vec_t mk(int len, int approx, logic [31:0] a, logic [31:0] b,
                              logic [11:0] gap, int dly, logic [23:0] e24, logic ov24,
                              logic [15:0] e16, logic ov16);
    vec_t v;
    v.len = len; v.approx = approx; v.a = a; v.b = b; v.gap = gap; v.dly = dly;
    v.e24 = e24; v.ov24 = ov24; v.e16 = e16; v.ov16 = ov16;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue_pair(input logic [7:0] a, input logic [7:0] b, output int t_hs);
    int waited;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    waited = 0;
    t_hs = -1;
    while (waited < 50) begin
      @(negedge clk);
      if (in_ready) begin
        t_hs = cyc;
        break;
      end
      waited++;
    end
    if (t_hs < 0) check("handshake_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int vi);
    vec_t v;
    exp_t e;
    int t_last;
    int waited;
    v = vecs[vi];
    @(posedge clk);
    #1;
    start = 1'b1;
    len_in = 8'(v.len);
    approx_in = 3'(v.approx);
    t_last = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < v.len; k++) begin
      repeat (int'(v.gap[k])) begin
        @(posedge clk);
        #1;
      end
      issue_pair(v.a[k], v.b[k], t_last);
    end
    sb.push_back('{e24: v.e24, ov24: v.ov24, e16: v.e16, ov16: v.ov16});

    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 40) begin
      if (v.len == 0) check("len0_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      waited++;
    end
    check("out_valid_seen", 32'(out_valid), 1);
    check("latency", 32'(cyc - t_last), (v.len == 0) ? 1 : 2 + ML);
    check("valid16_aligned", 32'(out_valid16), 1);

    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      for (int d = 0; d < v.dly; d++) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_acc", 32'(out_acc), 32'(e.e24));
        check("hold_acc16", 32'(out_acc16), 32'(e.e16));
        if (v.len == 0) check("len0_in_ready", 32'(in_ready), 0);
        @(negedge clk);
      end
      check("acc24", 32'(out_acc), 32'(e.e24));
      check("ovf24", 32'(overflow), 32'(e.ov24));
      check("acc16", 32'(out_acc16), 32'(e.e16));
      check("ovf16", 32'(overflow16), 32'(e.ov16));
      check("busy_done", 32'(busy), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(out_valid), 0);
    check("busy_idle", 32'(busy), 0);
    $display("job %0d: len=%0d approx=%0d acc24=%0d ovf24=%0d acc16=%0d ovf16=%0d",
             vi, v.len, v.approx, out_acc, overflow, out_acc16, overflow16);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_out_acc"}, 32'(out_acc), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_ovf16"}, 32'(overflow16), 0);
    check({tag, "_mul_a"}, 32'(mul_a), 0);
    check({tag, "_mul_b"}, 32'(mul_b), 0);
  endtask

  initial begin
    int t_dummy;
    // Packed fields list element 3 first: {x3, x2, x1, x0}.
    vecs[0] = mk(4, 0, {8'd0, 8'd255, 8'd10, 8'd3}, {8'd7, 8'd255, 8'd20, 8'd5},
                 12'd0, 0, 24'd65240, 1'b0, 16'd65240, 1'b0);
    vecs[1] = mk(0, 0, 32'd0, 32'd0, 12'd0, 1, 24'd0, 1'b0, 16'd0, 1'b0);
    vecs[2] = mk(1, 4, {24'd0, 8'd255}, {24'd0, 8'd255}, 12'd0, 0,
                 24'd65024, 1'b0, 16'd65024, 1'b0);
    vecs[3] = mk(2, 0, {16'd0, 8'd255, 8'd255}, {16'd0, 8'd255, 8'd255}, 12'd0, 0,
                 24'd130050, 1'b0, 16'd64514, 1'b1);
    vecs[4] = mk(1, 0, {24'd0, 8'd1}, {24'd0, 8'd1}, 12'd0, 0, 24'd1, 1'b0, 16'd1, 1'b0);
    vecs[5] = mk(4, 2, {8'd17, 8'd200, 8'd100, 8'd7}, {8'd17, 8'd201, 8'd3, 8'd9},
                 {3'd0, 3'd0, 3'd2, 3'd0}, 5, 24'd40848, 1'b0, 16'd40848, 1'b0);
    vecs[6] = mk(1, 0, {24'd0, 8'd2}, {24'd0, 8'd3}, 12'd0, 0, 24'd6, 1'b0, 16'd6, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(i);

    // Abort a job after two of four pairs with an asynchronous reset.
    @(posedge clk);
    #1;
    start = 1'b1;
    len_in = 8'd4;
    approx_in = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    issue_pair(8'd50, 8'd60, t_dummy);
    issue_pair(8'd70, 8'd80, t_dummy);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 1);
    check("abort_acc_nonzero", 32'(out_acc != 0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_valid", 32'(out_valid | out_valid16), 0);
      check("post_reset_busy", 32'(busy), 0);
    end
    $display("abort: reset during RUN, outputs cleared");

    run_job(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
